bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-005 The block SHALL have port load_valid, input, 1 bit: load_data is presented for transfer.
REQ-006 The block SHALL have port load_data, input, WIDTH bits: parallel word to serialise.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 The block SHALL have port shift_en, input, 1 bit: the downstream stage consumes one bit this cycle.
REQ-009 The block SHALL have port data_out, output, 1 bit: serial bit driven to the downstream data_in of the ones-detector stage.
REQ-010 The block SHALL have port bit_valid, output, 1 bit: data_out carries a frame bit and is consumed this cycle.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last bit of a word is consumed.
REQ-012 The block SHALL have port bit_cnt, output, clog2(WIDTH) bits: index (0-based, in transmit order) of the bit on data_out.

Function
REQ-013 The block SHALL implement two states: IDLE and SHIFT.
REQ-014 Accept SHALL occur on a rising edge where load_valid=1 and load_ready=1; no other condition loads a word.
REQ-015 load_ready SHALL be combinational: 1 in IDLE, and 1 in SHIFT only when shift_en=1 and bit_cnt=WIDTH-1; 0 otherwise.
REQ-016 On accept, the word SHALL be captured into a shift register; next cycle state=SHIFT, bit_cnt=0, data_out = first bit per MSB_FIRST (one-cycle load-to-first-bit latency).
REQ-017 In SHIFT, bit_valid SHALL equal shift_en; in IDLE, bit_valid SHALL be 0.
REQ-018 In SHIFT with shift_en=1 and bit_cnt<WIDTH-1, the next edge SHALL advance the shift register by one bit and increment bit_cnt.
REQ-019 In SHIFT with shift_en=0, data_out, bit_cnt and the shift register SHALL hold (pause has no timeout).
REQ-020 On the edge consuming bit WIDTH-1 (shift_en=1), frame_done SHALL be 1 during the following cycle only.
REQ-021 On that same edge, with load_valid=1, the new word SHALL be accepted: state stays SHIFT, bit_cnt=0, no idle gap (back-to-back frames).
REQ-022 On that same edge, with load_valid=0, state SHALL go to IDLE, data_out=0, bit_cnt=0.
REQ-023 load_valid while busy (load_ready=0) SHALL be ignored with no effect on the current frame; the upstream holds load_data and load_valid until accepted.
REQ-024 In IDLE, data_out SHALL be 0, so a downstream ones-counter sees no spurious ones between frames.
REQ-025 data_out, bit_valid-qualifying state, bit_cnt and frame_done SHALL be registered; only load_ready and bit_valid are combinational.

Reset
REQ-026 While reset=0, state SHALL be IDLE; the shift register, bit_cnt, data_out and frame_done SHALL be 0, independent of clk.
REQ-027 Assertion of reset mid-frame SHALL abort the frame with no frame_done pulse; the remaining bits are discarded.
REQ-028 After reset deasserts, the first rising edge SHALL be able to accept a word (load_ready=1).

Verification
REQ-029 The bench SHALL cover: WIDTH=8, MSB_FIRST=1, load 8'hF0 with shift_en=1 held -> data_out 1,1,1,1,0,0,0,0 on 8 consecutive cycles, frame_done high in cycle 9, downstream detector registers exactly four ones.
REQ-030 The bench SHALL cover: load 8'hA5, shift_en=0 for 3 cycles after bit_cnt=2 -> data_out and bit_cnt hold at bit index 2 (value 1) for those 3 cycles, frame completes after 11 cycles total.
REQ-031 The bench SHALL cover: load_valid held with 8'hFF then 8'h0F -> load_ready high on the 8th bit, second frame starts with no gap, and frame_done pulses twice, 8 cycles apart.
REQ-032 The bench SHALL cover: reset=0 asserted asynchronously at bit_cnt=5 -> data_out=0, bit_cnt=0, state IDLE immediately, no frame_done.
REQ-033 The bench SHALL cover: MSB_FIRST=0, load 8'h01 -> data_out 1 then seven 0s, and a load_valid pulse mid-frame with 8'hFF is ignored (load_ready=0).

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word with a ready/valid
// handshake and emits it one bit per shift_en cycle, with back-to-back frames.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             data_out,
    output logic             bit_valid,
    output logic             frame_done,
    output logic [CW-1:0]    bit_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state, state_d;
    logic [WIDTH-1:0] shift_reg, shift_reg_d;
    logic [CW-1:0]    bit_cnt_d;
    logic             data_out_d;
    logic             frame_done_d;
    logic             last_bit;
    logic             accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            data_out   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            shift_reg  <= shift_reg_d;
            bit_cnt    <= bit_cnt_d;
            data_out   <= data_out_d;
            frame_done <= frame_done_d;
        end
    end

    // data_out always holds the bit at the head of shift_reg, so on an
    // advance the next head is preloaded from the neighbouring position.
    always_comb begin
        state_d      = state;
        shift_reg_d  = shift_reg;
        bit_cnt_d    = bit_cnt;
        data_out_d   = data_out;
        frame_done_d = 1'b0;

        last_bit   = (state == SHIFT) && shift_en && (bit_cnt == LAST_IDX);
        load_ready = (state == IDLE) || last_bit;
        accept     = load_valid && load_ready;
        bit_valid  = (state == SHIFT) && shift_en;

        if (last_bit) begin
            frame_done_d = 1'b1;
        end

        if (accept) begin
            state_d     = SHIFT;
            shift_reg_d = load_data;
            bit_cnt_d   = '0;
            data_out_d  = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
        end else if (last_bit) begin
            state_d     = IDLE;
            shift_reg_d = '0;
            bit_cnt_d   = '0;
            data_out_d  = 1'b0;
        end else if (bit_valid) begin
            bit_cnt_d = bit_cnt + CNT_ONE;
            if (MSB_FIRST != 0) begin
                shift_reg_d = {shift_reg[WIDTH-2:0], 1'b0};
                data_out_d  = shift_reg[WIDTH-2];
            end else begin
                shift_reg_d = {1'b0, shift_reg[WIDTH-1:1]};
                data_out_d  = shift_reg[1];
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: vector table, hand-written corner
// sequences and random traffic against a bit-queue reference model.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid, shift_en;
    logic [7:0] load_data;
    logic       load_ready, data_out, bit_valid, frame_done;
    logic [2:0] bit_cnt;

    logic       lv_l, se_l;
    logic [7:0] ld_l;
    logic       ready_l, dout_l, valid_l, fd_l;
    logic [2:0] cnt_l;

    int checks = 0;
    int errors = 0;

    bit exp_q[$];
    bit fd_m = 1'b0;
    bit last_acc = 1'b0;
    int ones = 0;

    typedef struct {
        logic       lv;
        logic [7:0] ld;
        logic       se;
        logic       e_dout;
        logic [2:0] e_cnt;
        logic       e_fd;
        logic       e_ready;
    } vec_t;
    vec_t tbl[11];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .shift_en(shift_en), .data_out(data_out),
        .bit_valid(bit_valid), .frame_done(frame_done), .bit_cnt(bit_cnt)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .load_valid(lv_l), .load_data(ld_l),
        .load_ready(ready_l), .shift_en(se_l), .data_out(dout_l),
        .bit_valid(valid_l), .frame_done(fd_l), .bit_cnt(cnt_l)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic lv, input logic [7:0] ld, input logic se);
        load_valid = lv;
        load_data  = ld;
        shift_en   = se;
        #1;
    endtask

    // Compare the MSB-first DUT with the model, then advance one clock.
    task automatic checkOutput();
        bit busy, e_ready, e_valid, e_dout, acc;
        int e_cnt;
        logic [7:0] word;
        busy    = exp_q.size() != 0;
        e_ready = !busy || (shift_en && exp_q.size() == 1);
        e_valid = busy && shift_en;
        e_dout  = busy ? exp_q[0] : 1'b0;
        e_cnt   = busy ? 8 - exp_q.size() : 0;
        chk("model_ready", int'(load_ready), int'(e_ready));
        chk("model_valid", int'(bit_valid), int'(e_valid));
        chk("model_dout", int'(data_out), int'(e_dout));
        chk("model_cnt", int'(bit_cnt), e_cnt);
        chk("model_fd", int'(frame_done), int'(fd_m));
        acc  = load_valid && e_ready;
        word = load_data;
        @(posedge clk);
        if (e_valid && e_dout) ones++;
        fd_m = e_valid && exp_q.size() == 1;
        if (e_valid) void'(exp_q.pop_front());
        if (acc) for (int i = 7; i >= 0; i--) exp_q.push_back(word[i]);
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput();
    endtask

    initial begin
        int fd_at[$];
        int t;
        logic [7:0] w;
        bit cur_lv;
        logic [7:0] cur_ld;

        tbl[0]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};

        reset = 1'b0;
        lv_l = 1'b0; ld_l = 8'h00; se_l = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("rst_dout", int'(data_out), 0);
        chk("rst_cnt", int'(bit_cnt), 0);
        chk("rst_fd", int'(frame_done), 0);
        chk("rst_ready", int'(load_ready), 1);
        chk("rst_valid", int'(bit_valid), 0);
        reset = 1'b1;

        // Table: 8'hF0 with shift_en held, ones seen downstream.
        ones = 0;
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].lv, tbl[i].ld, tbl[i].se);
            chk($sformatf("tbl%0d_dout", i), int'(data_out), int'(tbl[i].e_dout));
            chk($sformatf("tbl%0d_cnt", i), int'(bit_cnt), int'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_fd", i), int'(frame_done), int'(tbl[i].e_fd));
            chk($sformatf("tbl%0d_ready", i), int'(load_ready), int'(tbl[i].e_ready));
            checkOutput();
        end
        chk("f0_ones", ones, 4);

        // 8'hA5 with a three-cycle pause at bit index 2.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput();
        t = 0;
        for (int c = 1; c <= 20 && t == 0; c++) begin
            applyStimulus(1'b0, 8'h00, !(c >= 3 && c <= 5));
            if (c >= 3 && c <= 5) begin
                chk("a5_hold_cnt", int'(bit_cnt), 2);
                chk("a5_hold_dout", int'(data_out), 1);
            end
            if (frame_done) t = c;
            checkOutput();
        end
        chk("a5_frame_cycles", t - 1, 11);

        // Back-to-back: 8'hFF then 8'h0F with load_valid held.
        applyStimulus(1'b1, 8'hFF, 1'b1);
        checkOutput();
        for (int c = 1; c <= 18; c++) begin
            applyStimulus(c <= 8, 8'h0F, 1'b1);
            if (c == 8) chk("b2b_ready_last", int'(load_ready), 1);
            if (c == 9) chk("b2b_no_gap_cnt", int'(bit_cnt), 0);
            if (frame_done) fd_at.push_back(c);
            checkOutput();
        end
        chk("b2b_fd_count", fd_at.size(), 2);
        if (fd_at.size() == 2) chk("b2b_fd_spacing", fd_at[1] - fd_at[0], 8);

        // Asynchronous reset at bit_cnt 5.
        applyStimulus(1'b1, 8'h3C, 1'b1);
        checkOutput();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput();
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        chk("arst_pre_cnt", int'(bit_cnt), 5);
        reset = 1'b0;
        #1;
        chk("arst_dout", int'(data_out), 0);
        chk("arst_cnt", int'(bit_cnt), 0);
        chk("arst_ready", int'(load_ready), 1);
        chk("arst_valid", int'(bit_valid), 0);
        exp_q.delete();
        fd_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("arst_no_fd", int'(frame_done), 0);
        reset = 1'b1;
        applyStimulus(1'b1, 8'h81, 1'b0);
        chk("arst_first_ready", int'(load_ready), 1);
        checkOutput();
        for (int c = 0; c < 9; c++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput();
        end

        // LSB-first: 8'h01 with an ignored mid-frame load pulse.
        lv_l = 1'b1; ld_l = 8'h01; se_l = 1'b1;
        idleCycle();
        w = 8'h01;
        for (int i = 0; i < 8; i++) begin
            lv_l = (i == 3);
            ld_l = (i == 3) ? 8'hFF : 8'h00;
            #1;
            chk("lsb_dout", int'(dout_l), int'(w[i]));
            chk("lsb_cnt", int'(cnt_l), i);
            if (i == 3) chk("lsb_busy_ready", int'(ready_l), 0);
            idleCycle();
        end
        lv_l = 1'b0;
        #1;
        chk("lsb_fd", int'(fd_l), 1);
        chk("lsb_idle_valid", int'(valid_l), 0);
        idleCycle();
        chk("lsb_fd_once", int'(fd_l), 0);
        chk("lsb_idle_dout", int'(dout_l), 0);
        se_l = 1'b0;

        // Random traffic with a holding upstream.
        cur_lv = 1'b0;
        cur_ld = 8'h00;
        for (int c = 0; c < 600; c++) begin
            if (!cur_lv || last_acc) begin
                cur_lv = $urandom_range(0, 2) == 0;
                cur_ld = 8'($urandom);
            end
            applyStimulus(cur_lv, cur_ld, $urandom_range(0, 3) != 0);
            checkOutput();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
